sprite_update_ctrl: RTL
=======================

Name: sprite_update_ctrl

Overview:
Configuration and sequencing controller for one mini sprite. It holds CPU-writable shadow copies of the sprite position and scale, and commits them atomically to the sprite at the start of vertical blank so a frame never shows a torn update. It also contains a copy engine that streams a bitmap from a source memory into the sprite bitmap write port at one pixel per cycle. It sits between the CPU register bus and the sprite's x/y/scale/bitmap inputs.

Parameters:
BPP, 8, pixel width in bits.
ADDR_BITS, 13, sprite bitmap address width; the bitmap holds 1<<ADDR_BITS pixels.
SRC_ADDR_BITS, 16, source memory address width.
V_ACTIVE, 480, first vblank line; vblank is ext_count_v >= V_ACTIVE.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
reg_addr  in  3  register select
reg_din  in  32  register write data
reg_we  in  1  register write strobe
reg_dout  out  32  registered read data for reg_addr, valid 1 cycle after the address is applied
ext_count_h  in  32  signed horizontal counter
ext_count_v  in  32  signed vertical counter
x  out  32  committed sprite x, signed
y  out  32  committed sprite y, signed
scale  out  32  committed scale
src_addr  out  SRC_ADDR_BITS  source read address
src_re  out  1  source read enable
src_data  in  BPP  source data, valid exactly 1 cycle after src_re
bitmap_address  out  32  sprite bitmap write address
bitmap_din  out  BPP  sprite bitmap write data
bitmap_we  out  1  sprite bitmap write enable
copy_done  out  1  one-cycle pulse after the final bitmap write
frame_commit  out  1  one-cycle pulse on the cycle the shadow values are committed

Behaviour:
- Register map (write), selected by reg_addr:
  - 0 = X_SH
  - 1 = Y_SH
  - 2 = SCALE_SH
  - 3 = COPY_LEN (low ADDR_BITS+1 bits)
  - 4 = COPY_SRC (low SRC_ADDR_BITS bits)
  - 5 = COPY_START (any write starts a copy)
  - 6, 7 = ignored
- Register map (read): addresses 0-4 return the stored value; address 6 returns {30'b0, busy, pending}; all other addresses return 0.
- Reset values: all of the following are 0 — every shadow register, x, y, scale, pending, src_addr, src_re, bitmap_address, bitmap_din, bitmap_we, copy_done, frame_commit, reg_dout. The FSM returns to IDLE.
- Shadow commit:
  - A write to address 0, 1 or 2 sets pending.
  - vblank_start is the single cycle where ext_count_v == V_ACTIVE and ext_count_h == 0.
  - On vblank_start with pending=1: x/y/scale are loaded from the shadows on the next edge, pending clears, and frame_commit pulses in that same cycle.
  - On vblank_start with pending=0: nothing changes and frame_commit stays 0.
- Simultaneous shadow write and vblank_start: the commit uses the pre-write shadow values, the new value is stored, and pending remains 1 so it commits next frame.
- Copy FSM states:
  - IDLE: on a COPY_START write, latch len = min(COPY_LEN, 1<<ADDR_BITS) and src = COPY_SRC, and set i = 0. If len == 0, pulse copy_done the next cycle and stay in IDLE. Otherwise go to RUN.
  - RUN: each cycle drive src_re=1 and src_addr = src+i (wraps modulo 2^SRC_ADDR_BITS), then i++. After issuing i = len-1, go to DRAIN.
  - DRAIN: one cycle for the last in-flight read, then go to IDLE and pulse copy_done.
- Write pipeline: one cycle after each read, drive bitmap_we=1, bitmap_address = the index of that read, and bitmap_din = src_data. Throughput is 1 pixel/cycle; a copy of N pixels takes N+1 cycles from the first src_re to the last write.
- busy = (state != IDLE). A COPY_START write while busy is ignored. Shadow writes are accepted at any time.
- Reset mid-copy: bitmap_we and src_re drop on the next cycle, the FSM goes to IDLE, and no copy_done pulse is produced.
- The copy engine and the shadow commit are independent and may happen in the same cycle.

Optional Feature:
COPY_VBLANK_ONLY_EN
- Defined: RUN issues reads only while ext_count_v >= V_ACTIVE. Outside vblank, src_re=0 and i holds; a read already in flight still completes its write on the next cycle. The copy resumes automatically at the next vblank, so the bitmap is never modified during active display.
- Undefined: the copy runs continuously regardless of the counters.

Test Plan:
1. Reset, write X_SH=100, Y_SH=50, SCALE_SH=8 at line 10 → x/y/scale stay 0 until line 480 h=0; then x=100, y=50, scale=8, frame_commit pulses once, and status reads 0.
2. Write X_SH=7 on exactly the vblank_start cycle while X_SH=3 is pending → x=3 this frame, pending=1, and x=7 at the next frame's vblank_start.
3. COPY_SRC=0x100, COPY_LEN=4, COPY_START → src_addr 0x100..0x103 on 4 consecutive cycles, bitmap writes to addresses 0..3 with the source data, and copy_done 1 cycle after the last write; a second COPY_START while busy has no effect.
4. COPY_LEN=0 → copy_done pulses and there are no src_re/bitmap_we cycles; COPY_LEN=9000 with ADDR_BITS=13 → exactly 8192 writes.
5. Assert reset after 10 writes of a 100-pixel copy → bitmap_we=0 next cycle, status busy=0, no copy_done pulse.
6. With COPY_VBLANK_ONLY_EN defined, start a 64-pixel copy at line 100 → no writes until line 480, then 64 consecutive writes.

Source files
------------

// File: rtl/sprite_update_ctrl.sv
// rtl/sprite_update_ctrl.sv - sprite shadow-register commit and bitmap copy engine
// Optional build macro: COPY_VBLANK_ONLY_EN restricts copy reads to vertical blank.
module sprite_update_ctrl #(
  parameter int BPP           = 8,
  parameter int ADDR_BITS     = 13,
  parameter int SRC_ADDR_BITS = 16,
  parameter int V_ACTIVE      = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               reg_addr,
  input  logic [31:0]              reg_din,
  input  logic                     reg_we,
  output logic [31:0]              reg_dout,
  input  logic [31:0]              ext_count_h,
  input  logic [31:0]              ext_count_v,
  output logic [31:0]              x,
  output logic [31:0]              y,
  output logic [31:0]              scale,
  output logic [SRC_ADDR_BITS-1:0] src_addr,
  output logic                     src_re,
  input  logic [BPP-1:0]           src_data,
  output logic [31:0]              bitmap_address,
  output logic [BPP-1:0]           bitmap_din,
  output logic                     bitmap_we,
  output logic                     copy_done,
  output logic                     frame_commit
);

  localparam int LW = ADDR_BITS + 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  logic [31:0]              x_sh_q, y_sh_q, scale_sh_q;
  logic [31:0]              x_q, y_q, scale_q;
  logic [LW-1:0]            copy_len_q;
  logic [SRC_ADDR_BITS-1:0] copy_src_q;
  logic                     pending_q;
  logic                     frame_commit_q;
  logic [31:0]              reg_dout_q;
  logic [31:0]              rd_mux;

  state_t                   state_q, state_d;
  logic [LW-1:0]            i_q, i_d;
  logic [LW-1:0]            len_q, len_d;
  logic [SRC_ADDR_BITS-1:0] src_q, src_d;
  logic                     done_q, done_d;
  logic                     we_q;
  logic [LW-1:0]            waddr_q;
  logic                     issue;
  logic                     rd_ok;
  logic                     busy;
  logic                     vblank_start;
  logic                     wr_shadow;
  logic                     wr_start;

  assign vblank_start = ($signed(ext_count_v) == V_ACTIVE) && (ext_count_h == 32'd0);
  assign wr_shadow    = reg_we && (reg_addr <= 3'd2);
  assign wr_start     = reg_we && (reg_addr == 3'd5);
  assign busy         = (state_q != S_IDLE);

`ifdef COPY_VBLANK_ONLY_EN
  assign rd_ok = ($signed(ext_count_v) >= V_ACTIVE);
`else
  assign rd_ok = 1'b1;
`endif

  // A commit always takes the pre-edge shadows; a coincident shadow write keeps pending set.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_sh_q         <= '0;
      y_sh_q         <= '0;
      scale_sh_q     <= '0;
      copy_len_q     <= '0;
      copy_src_q     <= '0;
      x_q            <= '0;
      y_q            <= '0;
      scale_q        <= '0;
      pending_q      <= 1'b0;
      frame_commit_q <= 1'b0;
    end else begin
      frame_commit_q <= 1'b0;
      if (vblank_start && pending_q) begin
        x_q            <= x_sh_q;
        y_q            <= y_sh_q;
        scale_q        <= scale_sh_q;
        frame_commit_q <= 1'b1;
      end
      if (wr_shadow) begin
        pending_q <= 1'b1;
      end else if (vblank_start) begin
        pending_q <= 1'b0;
      end
      if (reg_we) begin
        case (reg_addr)
          3'd0:    x_sh_q     <= reg_din;
          3'd1:    y_sh_q     <= reg_din;
          3'd2:    scale_sh_q <= reg_din;
          3'd3:    copy_len_q <= reg_din[LW-1:0];
          3'd4:    copy_src_q <= reg_din[SRC_ADDR_BITS-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (reg_addr)
      3'd0:    rd_mux = x_sh_q;
      3'd1:    rd_mux = y_sh_q;
      3'd2:    rd_mux = scale_sh_q;
      3'd3:    rd_mux = 32'(copy_len_q);
      3'd4:    rd_mux = 32'(copy_src_q);
      3'd6:    rd_mux = {30'd0, busy, pending_q};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_dout_q <= '0;
    end else begin
      reg_dout_q <= rd_mux;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    len_d   = len_q;
    src_d   = src_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_start) begin
          src_d = copy_src_q;
          i_d   = '0;
          len_d = (copy_len_q > MAX_LEN) ? MAX_LEN : copy_len_q;
          if (len_d == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (rd_ok) begin
          issue = 1'b1;
          i_d   = i_q + LW'(1);
          if (i_q == len_q - LW'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write side trails the read by one cycle so src_data lands directly on bitmap_din.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      len_q   <= '0;
      src_q   <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      len_q   <= len_d;
      src_q   <= src_d;
      done_q  <= done_d;
      we_q    <= issue;
      if (issue) begin
        waddr_q <= i_q;
      end
    end
  end

  assign src_re         = issue;
  assign src_addr       = SRC_ADDR_BITS'(32'(src_q) + 32'(i_q));
  assign bitmap_we      = we_q;
  assign bitmap_address = 32'(waddr_q);
  assign bitmap_din     = we_q ? src_data : '0;
  assign copy_done      = done_q;
  assign frame_commit   = frame_commit_q;
  assign reg_dout       = reg_dout_q;
  assign x              = x_q;
  assign y              = y_q;
  assign scale          = scale_q;

endmodule
